// File: rtl/fpga_scan_loader_if.sv
// Host-side configuration word handshake for fpga_scan_loader.
interface fpga_scan_loader_if #(
  parameter int WORD_WIDTH = 8
);
  logic [WORD_WIDTH-1:0] cfg_data;
  logic                  cfg_valid;
  logic                  cfg_ready;

  modport master (output cfg_data, cfg_valid, input cfg_ready);
  modport slave  (input cfg_data, cfg_valid, output cfg_ready);
endinterface

// File: rtl/fpga_scan_loader.sv
// Serialises host config words LSB-first onto the fabric connection scan chain.
// Optional chain readback of displaced contents: define FPGA_SCAN_READBACK_EN.
module fpga_scan_loader #(
  parameter int CHAIN_LEN  = 1024,
  parameter int WORD_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                 scan_clk,
  input  logic                 scan_rst_n,
  input  logic                 start,
  input  logic                 abort,
  fpga_scan_loader_if.slave    cfg,
  output logic                 conn_scan_en,
  output logic                 conn_scan_in,
  input  logic                 conn_scan_out,
  output logic                 busy,
  output logic                 done,
  output logic                 aborted,
  output logic [CNT_WIDTH-1:0] bit_count
`ifdef FPGA_SCAN_READBACK_EN
  ,
  output logic [WORD_WIDTH-1:0] rb_data,
  output logic                  rb_valid
`endif
);
  localparam int BW = $clog2(WORD_WIDTH + 1);
  localparam logic [CNT_WIDTH-1:0] CHAIN_END = CNT_WIDTH'(CHAIN_LEN);
  localparam logic [CNT_WIDTH-1:0] WORD_C    = CNT_WIDTH'(WORD_WIDTH);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, FINISH} state_t;

  state_t                state;
  logic [WORD_WIDTH-1:0] shreg;
  logic [BW-1:0]         rem;
  logic [CNT_WIDTH-1:0]  left;
  logic [BW-1:0]         btw;
  logic                  accept;

  // Last word of a chain that is not a word multiple carries only the remaining bits.
  assign left   = CHAIN_END - bit_count;
  assign btw    = (left < WORD_C) ? left[BW-1:0] : BW'(WORD_WIDTH);
  assign accept = (state == LOAD) && !abort && cfg.cfg_valid && cfg.cfg_ready;

  always_ff @(posedge scan_clk or negedge scan_rst_n) begin
    if (!scan_rst_n) begin
      state         <= IDLE;
      shreg         <= '0;
      rem           <= '0;
      cfg.cfg_ready <= 1'b0;
      conn_scan_en  <= 1'b0;
      conn_scan_in  <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      aborted       <= 1'b0;
      bit_count     <= '0;
    end else begin
      done    <= 1'b0;
      aborted <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !abort) begin
            state         <= LOAD;
            bit_count     <= '0;
            busy          <= 1'b1;
            cfg.cfg_ready <= 1'b1;
          end
        end
        LOAD: begin
          conn_scan_en <= 1'b0;
          conn_scan_in <= 1'b0;
          if (abort) begin
            state         <= IDLE;
            cfg.cfg_ready <= 1'b0;
            busy          <= 1'b0;
            aborted       <= 1'b1;
          end else if (accept) begin
            shreg         <= cfg.cfg_data;
            rem           <= btw;
            cfg.cfg_ready <= 1'b0;
            state         <= SHIFT;
          end
        end
        SHIFT: begin
          if (abort) begin
            state        <= IDLE;
            conn_scan_en <= 1'b0;
            conn_scan_in <= 1'b0;
            busy         <= 1'b0;
            aborted      <= 1'b1;
          end else begin
            conn_scan_en <= 1'b1;
            conn_scan_in <= shreg[0];
            shreg        <= shreg >> 1;
            bit_count    <= bit_count + 1'b1;
            rem          <= rem - 1'b1;
            // Raise ready while the last bit is still on the wire so words stream back-to-back.
            if (rem == BW'(1)) begin
              if (bit_count == CHAIN_END - 1'b1) begin
                state <= FINISH;
              end else begin
                state         <= LOAD;
                cfg.cfg_ready <= 1'b1;
              end
            end
          end
        end
        FINISH: begin
          conn_scan_en <= 1'b0;
          conn_scan_in <= 1'b0;
          done         <= 1'b1;
          busy         <= 1'b0;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef FPGA_SCAN_READBACK_EN
  logic [WORD_WIDTH-1:0] rb_asm;
  logic [WORD_WIDTH-1:0] rb_next;
  logic [BW-1:0]         rb_idx;
  logic [BW-1:0]         rb_len;
  logic                  rb_drop;

  assign rb_next = rb_asm | (WORD_WIDTH'(conn_scan_out) << rb_idx);
  assign rb_drop = abort && (state == LOAD || state == SHIFT);

  // The tail bit is displaced on every edge that sees conn_scan_en high, one edge after it was driven.
  always_ff @(posedge scan_clk or negedge scan_rst_n) begin
    if (!scan_rst_n) begin
      rb_asm   <= '0;
      rb_idx   <= '0;
      rb_len   <= '0;
      rb_data  <= '0;
      rb_valid <= 1'b0;
    end else begin
      rb_valid <= 1'b0;
      if (accept) rb_len <= btw;
      if (rb_drop) begin
        rb_asm <= '0;
        rb_idx <= '0;
      end else if (conn_scan_en) begin
        if (rb_idx == rb_len - 1'b1) begin
          rb_data  <= rb_next;
          rb_valid <= 1'b1;
          rb_asm   <= '0;
          rb_idx   <= '0;
        end else begin
          rb_asm <= rb_next;
          rb_idx <= rb_idx + 1'b1;
        end
      end
    end
  end
`else
  logic unused_scan_out;
  assign unused_scan_out = conn_scan_out;
`endif
endmodule

// File: tb/tb_fpga_scan_loader.sv
// Directed bench for fpga_scan_loader: chains of 16, 20 and 8 bits behind one observation mux.
module tb_fpga_scan_loader;
  logic scan_clk = 1'b0;
  logic scan_rst_n = 1'b0;
  always #5 scan_clk = ~scan_clk;

  int checks = 0, failures = 0;
  int sel = 0;
  int dk, hs, idle, ens, rises, rb_k;
  int en_cnt = 0, rise_cnt = 0, rb_cnt = 0;
  logic en_prev = 1'b0;
  logic [63:0] stream = '0;
  logic [7:0] chain8 = 8'h5A;

  logic start = 1'b0, abort = 1'b0, valid = 1'b0;
  logic [7:0] data = '0;
  logic [7:0] words [4];

  logic st [3], ab [3], en [3], sin [3], bsy [3], dn [3], abt [3], rdy [3];
  logic [15:0] bc [3];
  logic o_en, o_in, o_busy, o_done, o_ready;
`ifdef FPGA_SCAN_READBACK_EN
  logic [7:0] rb_data8;
  logic       rb_valid8;
`endif

  fpga_scan_loader_if #(.WORD_WIDTH(8)) if16 ();
  fpga_scan_loader_if #(.WORD_WIDTH(8)) if20 ();
  fpga_scan_loader_if #(.WORD_WIDTH(8)) if8 ();

  assign if16.cfg_data = data;  assign if16.cfg_valid = valid && sel == 0;
  assign if20.cfg_data = data;  assign if20.cfg_valid = valid && sel == 1;
  assign if8.cfg_data  = data;  assign if8.cfg_valid  = valid && sel == 2;
  assign rdy[0] = if16.cfg_ready;
  assign rdy[1] = if20.cfg_ready;
  assign rdy[2] = if8.cfg_ready;
  assign st[0] = start && sel == 0;  assign ab[0] = abort && sel == 0;
  assign st[1] = start && sel == 1;  assign ab[1] = abort && sel == 1;
  assign st[2] = start && sel == 2;  assign ab[2] = abort && sel == 2;

  fpga_scan_loader #(.CHAIN_LEN(16), .WORD_WIDTH(8), .CNT_WIDTH(16)) d16 (
    .scan_clk(scan_clk), .scan_rst_n(scan_rst_n), .start(st[0]), .abort(ab[0]), .cfg(if16),
    .conn_scan_en(en[0]), .conn_scan_in(sin[0]), .conn_scan_out(1'b0),
    .busy(bsy[0]), .done(dn[0]), .aborted(abt[0]), .bit_count(bc[0])
`ifdef FPGA_SCAN_READBACK_EN
    , .rb_data(), .rb_valid()
`endif
  );

  fpga_scan_loader #(.CHAIN_LEN(20), .WORD_WIDTH(8), .CNT_WIDTH(16)) d20 (
    .scan_clk(scan_clk), .scan_rst_n(scan_rst_n), .start(st[1]), .abort(ab[1]), .cfg(if20),
    .conn_scan_en(en[1]), .conn_scan_in(sin[1]), .conn_scan_out(1'b0),
    .busy(bsy[1]), .done(dn[1]), .aborted(abt[1]), .bit_count(bc[1])
`ifdef FPGA_SCAN_READBACK_EN
    , .rb_data(), .rb_valid()
`endif
  );

  fpga_scan_loader #(.CHAIN_LEN(8), .WORD_WIDTH(8), .CNT_WIDTH(16)) d8 (
    .scan_clk(scan_clk), .scan_rst_n(scan_rst_n), .start(st[2]), .abort(ab[2]), .cfg(if8),
    .conn_scan_en(en[2]), .conn_scan_in(sin[2]), .conn_scan_out(chain8[0]),
    .busy(bsy[2]), .done(dn[2]), .aborted(abt[2]), .bit_count(bc[2])
`ifdef FPGA_SCAN_READBACK_EN
    , .rb_data(rb_data8), .rb_valid(rb_valid8)
`endif
  );

  always_comb begin
    o_en    = en[sel];
    o_in    = sin[sel];
    o_busy  = bsy[sel];
    o_done  = dn[sel];
    o_ready = rdy[sel];
  end

  // Chain-side monitor: records what the selected chain actually shifts in.
  always @(posedge scan_clk) begin
    if (o_en) begin
      stream <= {stream[62:0], o_in};
      en_cnt <= en_cnt + 1;
    end
    if (o_en && !en_prev) rise_cnt <= rise_cnt + 1;
    en_prev <= o_en;
    if (en[2]) chain8 <= {sin[2], chain8[7:1]};
`ifdef FPGA_SCAN_READBACK_EN
    if (rb_valid8) rb_cnt <= rb_cnt + 1;
`endif
  end

  task automatic tick();
    @(posedge scan_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Full load on the selected DUT; k counts edges after the one that samples start.
  task automatic run_load(input bit stall);
    int k;
    bit hs_now;
    hs = 0; idle = 0; dk = -1; rb_k = -1;
    ens = en_cnt; rises = rise_cnt;
    data = words[0]; valid = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    k = 0;
    chk("busy_rise", o_busy, 1);
    while (dk < 0 && k < 80) begin
      if (o_ready && !o_en) idle++;
      if (stall && k == 1) valid = 1'b0;
      if (stall && k == 19) valid = 1'b1;
      hs_now = o_ready && valid;
      tick();
      k++;
      if (hs_now) begin
        hs++;
        data = words[hs & 3];
      end
      if (o_done) dk = k;
`ifdef FPGA_SCAN_READBACK_EN
      if (rb_valid8 && rb_k < 0) rb_k = k;
`endif
    end
    ens = en_cnt - ens;
    rises = rise_cnt - rises;
  endtask

  initial begin
    int base;
    words[0] = 8'hA5; words[1] = 8'h3C; words[2] = 8'h00; words[3] = 8'h00;
    repeat (3) tick();
    chk("rst_outputs", {rdy[0], en[0], sin[0], bsy[0], dn[0], abt[0]}, 0);
    chk("rst_bit_count", bc[0], 0);
`ifdef FPGA_SCAN_READBACK_EN
    chk("rst_rb", {rb_valid8, rb_data8}, 0);
`endif
    #3 scan_rst_n = 1'b1;
    tick();

    // Two full words, no stalls
    sel = 0;
    run_load(0);
    chk("a_done_cycle", dk, 19);
    chk("a_stream", stream[15:0], 16'hA53C);
    chk("a_en_cycles", ens, 16);
    chk("a_en_runs", rises, 2);
    chk("a_handshakes", hs, 2);
    chk("a_idle_cycles", idle, 1);
    chk("a_bit_count", bc[0], 16);
    chk("a_busy_low", bsy[0], 0);
    tick();
    chk("a_done_pulse", dn[0], 0);

    // Ten-cycle back-pressure after the first word
    run_load(1);
    chk("s_done_cycle", dk, 29);
    chk("s_stream", stream[15:0], 16'hA53C);
    chk("s_en_cycles", ens, 16);
    chk("s_idle_cycles", idle, 11);
    chk("s_handshakes", hs, 2);
    tick();

    // Partial final word: only the low 4 bits of 0xFA go out
    sel = 1;
    words[0] = 8'hFF; words[1] = 8'hFF; words[2] = 8'hFA;
    run_load(0);
    chk("b_done_cycle", dk, 24);
    chk("b_stream", stream[19:0], 20'hFFFF5);
    chk("b_en_cycles", ens, 20);
    chk("b_en_runs", rises, 3);
    chk("b_handshakes", hs, 3);
    chk("b_bit_count", bc[1], 20);
    tick();

    // Abort after five shifted bits
    sel = 0;
    data = 8'hA5; valid = 1'b1; base = en_cnt;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (6) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("c_abort_outs", {en[0], abt[0], bsy[0], dn[0], rdy[0]}, 5'b01000);
    chk("c_bit_count", bc[0], 5);
    chk("c_en_cycles", en_cnt - base, 5);
    tick();
    chk("c_pulse_end", {abt[0], dn[0], bsy[0]}, 0);

    // start and abort together in IDLE
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    chk("d_no_load", {bsy[0], abt[0], rdy[0]}, 0);
    tick();
    chk("d_still_idle", bsy[0], 0);

    // Reset during SHIFT, then a clean reload
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    chk("e_shifting", en[0], 1);
    #2 scan_rst_n = 1'b0;
    #1;
    chk("e_async_outs", {en[0], bsy[0], rdy[0]}, 0);
    chk("e_bit_count", bc[0], 0);
    tick();
    #3 scan_rst_n = 1'b1;
    tick();
    words[0] = 8'hA5; words[1] = 8'h3C; words[2] = 8'h00;
    run_load(0);
    chk("e_done_cycle", dk, 19);
    chk("e_stream", stream[15:0], 16'hA53C);
    chk("e_bit_count_full", bc[0], 16);
    tick();

    // Eight-bit chain preloaded with 0x5A
    sel = 2;
    words[0] = 8'h1E; words[1] = 8'h00;
    base = rb_cnt;
    run_load(0);
    chk("f_done_cycle", dk, 10);
    chk("f_stream", stream[7:0], 8'h78);
    chk("f_chain", chain8, 8'h1E);
    chk("f_handshakes", hs, 1);
`ifdef FPGA_SCAN_READBACK_EN
    chk("f_rb_data", rb_data8, 8'h5A);
    chk("f_rb_cycle", rb_k, 10);
    tick();
    chk("f_rb_pulses", rb_cnt - base, 1);
`endif
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
